// File: rtl/alm_pkg.sv
// Shared definitions for the approximate-MAC accumulation path.
//   alm_acc_state_e : accumulator FSM states (IDLE, ACCUM, DONE)
//   alm_len_w()     : width of a burst length/count field for a given LEN_MAX
//   ACC_MAX/ACC_MIN : signed saturation limits of a w-bit accumulator, returned
//                     sign-extended to ALM_CONST_W bits; callers size-cast them.
package alm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } alm_acc_state_e;

  localparam int unsigned ALM_CONST_W = 128;

  function automatic int unsigned alm_len_w(input int unsigned len_max);
    return $clog2(len_max + 1);
  endfunction

  // +2^(w-1)-1
  function automatic logic [ALM_CONST_W-1:0] ACC_MAX(input int unsigned w);
    logic [ALM_CONST_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // -2^(w-1), sign-extended
  function automatic logic [ALM_CONST_W-1:0] ACC_MIN(input int unsigned w);
    logic [ALM_CONST_W-1:0] r;
    r = '1;
    for (int unsigned i = 0; i < w - 1; i++) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alm_sat_adder.sv
// Combinational saturating signed adder.
//   a, b : ACC_WIDTH-bit two's complement operands
//   sum  : a + b clamped to [ACC_MIN, ACC_MAX]
//   ovf  : high when the clamp was applied
module alm_sat_adder
  import alm_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(ACC_MAX(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(ACC_MIN(ACC_WIDTH));

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // The top two bits of the one-bit-wider sum disagree exactly on overflow;
    // the very top bit carries the true sign and picks the clamp direction.
    ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (ovf) sum = wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    else     sum = wide[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/alm_dot_accumulator.sv
// Saturating dot-product accumulator for the approximate multiplier stream.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start, i_len        : start a burst of i_len products (clamped to LEN_MAX)
//   i_prod_valid/o_prod_ready/i_prod : signed 2*WIDTH-bit product input
//   o_res_valid/i_res_ready/o_res/o_sat : ACC_WIDTH-bit result and sticky
//                                         saturation flag
//   o_busy  : high in ACCUM and DONE
//   o_count : products accepted in the current burst
module alm_dot_accumulator
  import alm_pkg::*;
#(
  parameter  int unsigned WIDTH     = 16,
  parameter  int unsigned ACC_WIDTH = 40,
  parameter  int unsigned LEN_MAX   = 256,
  localparam int unsigned LEN_W     = alm_len_w(LEN_MAX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_prod_valid,
  output logic                 o_prod_ready,
  input  logic [2*WIDTH-1:0]   i_prod,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [ACC_WIDTH-1:0] o_res,
  output logic                 o_sat,
  output logic                 o_busy,
  output logic [LEN_W-1:0]     o_count
);

  localparam logic [LEN_W-1:0] LEN_MAX_V = LEN_W'(LEN_MAX);

  alm_acc_state_e       state;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     count_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 sat_q;
  logic                 prod_ready_q;
  logic                 res_valid_q;
  logic                 busy_q;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [LEN_W-1:0]     len_clamped;
  logic                 prod_hs;

  always_comb begin
    prod_ext    = {{(ACC_WIDTH-2*WIDTH){i_prod[2*WIDTH-1]}}, i_prod};
    len_clamped = (i_len > LEN_MAX_V) ? LEN_MAX_V : i_len;
    prod_hs     = i_prod_valid & prod_ready_q;
  end

  alm_sat_adder #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_adder (
    .a  (acc_q),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Handshake flags are registered alongside the state so that ready/valid
  // never depend combinationally on the opposite side of either port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            len_q   <= len_clamped;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (len_clamped != '0) begin
              state        <= ACCUM;
              prod_ready_q <= 1'b1;
            end else begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (prod_hs) begin
            acc_q   <= add_sum;
            count_q <= count_q + LEN_W'(1);
            sat_q   <= sat_q | add_ovf;
            if (count_q == len_q - LEN_W'(1)) begin
              state        <= DONE;
              prod_ready_q <= 1'b0;
              res_valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          prod_ready_q <= 1'b0;
          res_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_prod_ready = prod_ready_q;
    o_res_valid  = res_valid_q;
    o_res        = acc_q;
    o_sat        = sat_q;
    o_busy       = busy_q;
    o_count      = count_q;
  end

endmodule
